// File: rtl/hitegg_pkg.sv
// Shared types and constants for the hit/egg round controller.
package hitegg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPAWN    = 3'd1,
    ST_LATCH    = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_RESULT   = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_t;

  localparam logic [1:0] COL_NONE   = 2'b00;
  localparam logic [1:0] COL_GREEN  = 2'b01;
  localparam logic [1:0] COL_RED    = 2'b10;
  localparam logic [1:0] COL_YELLOW = 2'b11;

  localparam int PTS_GREEN  = 1;
  localparam int PTS_YELLOW = 2;

  // A usable target has exactly one of bits 16:1 set, bit 0 clear, and a real colour.
  function automatic logic target_ok(input logic [16:0] pos, input logic [1:0] col);
    logic [15:0] p;
    p = pos[16:1];
    return !pos[0] && (p != 16'd0) && ((p & (p - 16'd1)) == 16'd0) && (col != COL_NONE);
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer for asynchronous keys followed by a registered rising-edge pulse.
module key_edge_sync #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_async,
  output logic [N-1:0] o_rise
);

  logic [N-1:0] r_s1, r_s2, r_s3, r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_rise <= '0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/hit_judge.sv
// Round controller: requests a target, shows it, judges the player's key press and
// keeps score and lives.
module hit_judge
  import hitegg_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 1000,
  parameter int RESULT_TICKS  = 300,
  parameter int LIVES_INIT    = 3,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic [16:0]        position,
  input  logic [1:0]         color,
  input  logic [15:0]        hit_key,
  output logic               remake,
  output logic [15:0]        target_led,
  output logic [1:0]         target_color,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_over,
  output logic [2:0]         state_o
);

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W-1){1'b0}}, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  function automatic logic [1:0] dec_lives(input logic [1:0] l);
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

  state_t             r_state;
  logic [15:0]        r_tgt;
  logic [1:0]         r_col;
  logic [15:0]        r_timer;
  logic [SCORE_W-1:0] r_score;
  logic [1:0]         r_lives;
  logic               r_remake, r_hit, r_miss, r_game_over;

  logic [15:0] w_rise;
  logic        w_other, w_on_tgt, w_timeout, w_done;

  key_edge_sync #(.N(16)) u_keys (
    .clk     (clk),
    .rst     (rst),
    .i_async (hit_key),
    .o_rise  (w_rise)
  );

  assign w_other   = |(w_rise & ~r_tgt);
  assign w_on_tgt  = |(w_rise & r_tgt);
  assign w_timeout = (r_timer == 16'(TIMEOUT_TICKS));
  assign w_done    = (r_timer == 16'(RESULT_TICKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tgt       <= '0;
      r_col       <= COL_NONE;
      r_timer     <= '0;
      r_score     <= '0;
      r_lives     <= '0;
      r_remake    <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_remake <= 1'b0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_GAMEOVER: begin
          if (start) begin
            r_state     <= ST_SPAWN;
            r_remake    <= 1'b1;
            r_score     <= '0;
            r_lives     <= 2'(LIVES_INIT);
            r_game_over <= 1'b0;
          end
        end
        ST_SPAWN: r_state <= ST_LATCH;
        ST_LATCH: begin
          if (target_ok(position, color)) begin
            r_tgt   <= position[16:1];
            r_col   <= color;
            r_timer <= '0;
            r_state <= ST_ACTIVE;
          end else begin
            r_remake <= 1'b1;
            r_state  <= ST_SPAWN;
          end
        end
        ST_ACTIVE: begin
          // A stray key beats a target hit; any key edge beats the timeout.
          if (w_other || w_on_tgt || w_timeout) begin
            r_state <= ST_RESULT;
            r_timer <= '0;
            r_tgt   <= '0;
            r_col   <= COL_NONE;
            if (w_other) begin
              r_lives <= dec_lives(r_lives);
              r_miss  <= 1'b1;
            end else if (w_on_tgt) begin
              case (r_col)
                COL_GREEN: begin
                  r_score <= sat_add(r_score, 2'(PTS_GREEN));
                  r_hit   <= 1'b1;
                end
                COL_YELLOW: begin
                  r_score <= sat_add(r_score, 2'(PTS_YELLOW));
                  r_hit   <= 1'b1;
                end
                default: begin
                  r_lives <= dec_lives(r_lives);
                  r_miss  <= 1'b1;
                end
              endcase
            end else if (r_col != COL_RED) begin
              r_lives <= dec_lives(r_lives);
              r_miss  <= 1'b1;
            end
          end else if (tick) begin
            r_timer <= r_timer + 16'd1;
          end
        end
        ST_RESULT: begin
          if (w_done) begin
            r_timer <= '0;
            if (r_lives == 2'd0) begin
              r_state     <= ST_GAMEOVER;
              r_game_over <= 1'b1;
            end else begin
              r_state  <= ST_SPAWN;
              r_remake <= 1'b1;
            end
          end else if (tick) begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign remake       = r_remake;
  assign target_led   = r_tgt;
  assign target_color = r_col;
  assign score        = r_score;
  assign lives        = r_lives;
  assign hit_pulse    = r_hit;
  assign miss_pulse   = r_miss;
  assign game_over    = r_game_over;
  assign state_o      = r_state;

endmodule
